// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM encoding, reset defaults, opcodes.
package riscv_pkg;

  localparam int unsigned DEF_XLEN      = 32;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // TRAP is only reachable when FETCH_MISALIGN_TRAP_EN is defined
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } fetch_state_t;

  // Base opcodes consumed by control decode
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Field extractors for decode
  function automatic logic [6:0] get_opcode(input logic [31:0] ins);
    return ins[6:0];
  endfunction

  function automatic logic [2:0] get_funct3(input logic [31:0] ins);
    return ins[14:12];
  endfunction

  function automatic logic [6:0] get_funct7(input logic [31:0] ins);
    return ins[31:25];
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: sequential pc+4 or branch target, with alignment handling.
// Behaviour depends on macro FETCH_MISALIGN_TRAP_EN (raw target kept for trapping).
module pc_next_logic #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic            pc_src,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign
);

  // Adders wrap modulo 2^XLEN; target alignment chosen by build option
  always_comb begin
    pc_plus4 = pc + XLEN'(4);
    target   = pc + imm_ext;
    misalign = pc_src & (target[1:0] != 2'b00);
`ifdef FETCH_MISALIGN_TRAP_EN
    next_pc  = pc_src ? target : pc_plus4;
`else
    next_pc  = pc_src ? {target[XLEN-1:2], 2'b00} : pc_plus4;
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem request handshake, instruction register.
// Optional misaligned-branch trap enabled by macro FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEF_RESET_PC),
  parameter logic [31:0]     NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_src,
  input  logic [XLEN-1:0] imm_ext,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap
`endif
);

  fetch_state_t    state;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] target_unused;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misalign;
`else
  logic            misalign_unused;
`endif

  pc_next_logic #(.XLEN(XLEN)) u_pc_next (
    .pc       (pc),
    .imm_ext  (imm_ext),
    .pc_src   (pc_src),
    .pc_plus4 (pc_plus4),
    .target   (target_unused),
    .next_pc  (next_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign (misalign)
`else
    .misalign (misalign_unused)
`endif
  );

  // Request is a state decode, forced low while reset is held
  assign imem_req  = (state == FETCH) & ~rst;
  assign imem_addr = pc;

  // Fetch FSM and architectural registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      instr         <= NOP_INSTR;
      instr_valid   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misalign) begin
              misalign_trap <= 1'b1;
              state         <= TRAP;
            end else begin
              state <= FETCH;
            end
`else
            state <= FETCH;
`endif
          end
        end
        default: begin
          // TRAP is absorbing; only reset leaves it
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus hand sequences for wrap, misalign and reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_src;
  logic [31:0] imm_ext;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_src      (pc_src),
    .imm_ext     (imm_ext),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_trap (misalign_trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        src;
    logic [31:0] imm;
    logic        stl;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_valid;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int tests;
  int fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Check the common observable state after a cycle
  task automatic chk_state(input string tag, input logic e_req, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic e_valid);
    chk({tag, " req"},   32'(imem_req),    32'(e_req));
    chk({tag, " addr"},  imem_addr,        e_pc);
    chk({tag, " pc"},    pc,               e_pc);
    chk({tag, " pc4"},   pc_plus4,         e_pc + 32'd4);
    chk({tag, " instr"}, instr,            e_instr);
    chk({tag, " valid"}, 32'(instr_valid), 32'(e_valid));
  endtask

  task automatic drive(input logic s, input logic [31:0] im, input logic st,
                       input logic r, input logic [31:0] rd);
    pc_src     = s;
    imm_ext    = im;
    stall      = st;
    imem_ready = r;
    imem_rdata = rd;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    //            src imm           stl rdy rdata          req pc            instr          valid
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h00500093, 1'b0, 32'h00, 32'h00500093, 1'b1};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h04, 32'h00500093, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h11111111, 1'b0, 32'h04, 32'h11111111, 1'b1};
    vecs[3]  = '{1'b1, 32'hC,        1'b0, 1'b0, 32'h0,        1'b1, 32'h10, 32'h11111111, 1'b0};
    vecs[4]  = '{1'b1, 32'h100,      1'b1, 1'b0, 32'h0,        1'b1, 32'h10, 32'h11111111, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h10, 32'h11111111, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h10, 32'h11111111, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h22222222, 1'b0, 32'h10, 32'h22222222, 1'b1};
    vecs[8]  = '{1'b1, 32'h10,       1'b0, 1'b0, 32'h0,        1'b1, 32'h20, 32'h22222222, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h33333333, 1'b0, 32'h20, 32'h33333333, 1'b1};
    vecs[10] = '{1'b1, 32'hFFFFFFF0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10, 32'h33333333, 1'b0};
    vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h44444444, 1'b0, 32'h10, 32'h44444444, 1'b1};
    vecs[12] = '{1'b1, 32'h10,       1'b1, 1'b1, 32'h55555555, 1'b0, 32'h10, 32'h44444444, 1'b1};
    vecs[13] = '{1'b0, 32'h10,       1'b1, 1'b0, 32'h0,        1'b0, 32'h10, 32'h44444444, 1'b1};
    vecs[14] = '{1'b1, 32'h10,       1'b1, 1'b1, 32'h55555555, 1'b0, 32'h10, 32'h44444444, 1'b1};
    vecs[15] = '{1'b0, 32'h10,       1'b1, 1'b0, 32'h0,        1'b0, 32'h10, 32'h44444444, 1'b1};
    vecs[16] = '{1'b1, 32'h10,       1'b0, 1'b0, 32'h0,        1'b1, 32'h20, 32'h44444444, 1'b0};
    vecs[17] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h66666666, 1'b0, 32'h20, 32'h66666666, 1'b1};
    vecs[18] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h24, 32'h66666666, 1'b0};
    vecs[19] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h77777777, 1'b0, 32'h24, 32'h77777777, 1'b1};
    vecs[20] = '{1'b1, 32'h8,        1'b0, 1'b0, 32'h0,        1'b1, 32'h2C, 32'h77777777, 1'b0};
    vecs[21] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h88888888, 1'b0, 32'h2C, 32'h88888888, 1'b1};

    // Reset state
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    cycle();
    chk_state("reset", 1'b0, 32'h0, 32'h00000013, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("reset trap", 32'(misalign_trap), 32'h0);
`endif
    rst = 1'b0;
    #1;
    chk_state("first req", 1'b1, 32'h0, 32'h00000013, 1'b0);

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].src, vecs[i].imm, vecs[i].stl, vecs[i].rdy, vecs[i].rdata);
      cycle();
      chk_state($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_instr,
                vecs[i].e_valid);
    end

    // Branch to top of address space, then sequential wrap to 0
    drive(1'b1, 32'hFFFFFFD0, 1'b0, 1'b0, 32'h0);
    cycle();
    chk_state("to_top", 1'b1, 32'hFFFFFFFC, 32'h88888888, 1'b0);
    chk("top pc4 wrap", pc_plus4, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h99999999);
    cycle();
    chk_state("top fetch", 1'b0, 32'hFFFFFFFC, 32'h99999999, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle();
    chk_state("wrap", 1'b1, 32'h0, 32'h99999999, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAAAAAA);
    cycle();
    chk_state("wrap fetch", 1'b0, 32'h0, 32'hAAAAAAAA, 1'b1);

    // Misaligned branch target (offset 2)
    drive(1'b1, 32'h2, 1'b0, 1'b0, 32'h0);
    cycle();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk_state("misalign", 1'b0, 32'h2, 32'hAAAAAAAA, 1'b0);
    chk("misalign trap", 32'(misalign_trap), 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBBBBBB);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk_state($sformatf("trap%0d", k), 1'b0, 32'h2, 32'hAAAAAAAA, 1'b0);
      chk($sformatf("trap%0d flag", k), 32'(misalign_trap), 32'h1);
    end
`else
    chk_state("misalign", 1'b1, 32'h0, 32'hAAAAAAAA, 1'b0);
`endif

    // Asynchronous reset while a response is arriving
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst req low", 32'(imem_req), 32'h0);
    chk("rst pc async", pc, 32'h0);
    cycle();
    chk_state("rst mid", 1'b0, 32'h0, 32'h00000013, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst trap clr", 32'(misalign_trap), 32'h0);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    chk_state("post rst", 1'b1, 32'h0, 32'h00000013, 1'b0);
    cycle();
    chk_state("post rst wait", 1'b1, 32'h0, 32'h00000013, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h00A00113);
    cycle();
    chk_state("post rst fetch", 1'b0, 32'h0, 32'h00A00113, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the decode/control stage.
- Holds the PC and issues requests to instruction memory over a ready handshake.
- Presents the fetched instruction, whose opcode/funct3/funct7 fields feed control decode.
- Consumes the PCSrc and extended-immediate results of the current instruction to select the next PC: sequential or branch target.

Parameters:
XLEN, 32, datapath/PC width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction register value on reset (addi x0,x0,0)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
pc_src  input  1  branch taken (Branch & Zero from control), sampled in EXEC only
imm_ext  input  XLEN  sign-extended branch offset of current instruction
stall  input  1  hold current instruction in EXEC
imem_req  output  1  instruction memory request
imem_addr  output  XLEN  request address (= pc)
imem_rdata  input  32  returned instruction word
imem_ready  input  1  rdata valid this cycle; accepted only while imem_req=1
instr  output  32  current instruction register
instr_valid  output  1  instr holds a valid fetched instruction
pc  output  XLEN  PC of instr
pc_plus4  output  XLEN  pc + 4, combinational

Behaviour:
- States: FETCH, EXEC (TRAP only when the optional feature is compiled in).
- Reset (async, any state, including mid-request): state=FETCH, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0. imem_req deasserts immediately while rst=1.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Wait any number of cycles for imem_ready.
  - On imem_ready: instr<=imem_rdata, instr_valid<=1, go EXEC.
  - Minimum latency is one cycle from request to instr_valid.
- EXEC:
  - imem_req=0; instr_valid=1.
  - stall=1: hold instr, pc, and state. pc_src is ignored.
  - stall=0: pc <= pc_src ? (pc + imm_ext) : (pc + 4); instr_valid<=0; go FETCH.
- imem_ready outside FETCH is ignored; no instr update occurs.
- Arithmetic: all adds are modulo 2^XLEN, so the PC wraps silently (e.g. 0xFFFF_FFFC + 4 = 0).
- Target alignment, without the optional feature: bits [1:0] of the branch target are forced to 0.
- instr holds its last value in FETCH; consumers must qualify with instr_valid.
- Throughput: one instruction per 2 cycles minimum (FETCH + EXEC), with zero-wait memory.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_trap (1 bit) and state TRAP.
  - In EXEC with stall=0 and pc_src=1, if target[1:0]!=0: go TRAP. pc is loaded with the unmodified target, misalign_trap<=1, instr_valid<=0.
  - TRAP is absorbing: no requests are issued; only rst exits.
  - misalign_trap resets to 0.
- Undefined: no port, no TRAP state; target[1:0] is cleared as above.

Decomposition:
- Shared package riscv_pkg holds:
  - state encoding constants (FETCH, EXEC, TRAP)
  - NOP_INSTR, default RESET_PC
  - opcode constants reused by control decode
- One sub-module: pc_next_logic (combinational)
  - inputs: pc, imm_ext, pc_src
  - outputs: pc_plus4, branch target, next pc, misalign flag
- FSM and registers remain in fetch_unit.

Test Plan:
- Reset then zero-wait memory returning 0x00500093 at addr 0: imem_req=1 with imem_addr=0 in cycle 1; instr=0x00500093 and instr_valid=1 in cycle 2; next request at 0x4.
- 3-cycle imem_ready delay at pc=0x10: imem_addr stays 0x10 and instr_valid stays 0 for 3 cycles; instr is then captured.
- In EXEC with pc=0x20, pc_src=1, imm_ext=0xFFFFFFF0: next imem_addr=0x10. With pc_src=0: next imem_addr=0x24.
- stall=1 for 4 cycles in EXEC with pc_src toggling: instr, pc, instr_valid unchanged and imem_req=0; after release, next PC uses pc_src at the release cycle.
- rst asserted mid-FETCH with imem_ready arriving in the same cycle: pc=RESET_PC, instr=0x00000013, instr_valid=0; the returned word is dropped.
- pc=0xFFFF_FFFC, pc_src=0: wraps to imem_addr=0. With FETCH_MISALIGN_TRAP_EN, imm_ext=0x2: misalign_trap=1, imem_req stays 0 until rst.
